// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry {pc, instr} FIFO between fetch and decode with single-cycle flush.
// Optional FETCH_QUEUE_BYPASS_EN adds a zero-latency pass-through when the queue is empty.
module fetch_queue #(
    parameter int ADDR_WIDTH  = 12,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [ADDR_WIDTH-1:0]        enq_pc,
    input  logic [INSTR_WIDTH-1:0]       enq_instr,
    output logic                         deq_valid,
    input  logic                         deq_ready,
    output logic [ADDR_WIDTH-1:0]        deq_pc,
    output logic [INSTR_WIDTH-1:0]       deq_instr,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [PW-1:0]          rd_ptr, wr_ptr;
    logic                   stored, bypass, do_wr, do_rd;

    always_comb begin
        stored = count != '0;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass = !stored && enq_valid && !flush;
`else
        bypass = 1'b0;
`endif
        // Reset forces the handshake outputs even while the registers still hold old state
        enq_ready = reset || count != CW'(DEPTH);
        deq_valid = !reset && (stored || bypass);
        deq_pc    = reset ? '0 : stored ? pc_mem[rd_ptr] : bypass ? enq_pc : '0;
        deq_instr = reset ? '0 : stored ? instr_mem[rd_ptr] : bypass ? enq_instr : '0;
        do_rd     = stored && deq_ready && !flush;
        // A bypassed entry consumed this cycle never touches storage
        do_wr     = enq_valid && enq_ready && !flush && !(bypass && deq_ready);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= count + CW'(do_wr) - CW'(do_rd);
            rd_ptr <= do_rd ? rd_ptr + PW'(1) : rd_ptr;
            wr_ptr <= do_wr ? wr_ptr + PW'(1) : wr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !reset) begin
            pc_mem[wr_ptr]    <= enq_pc;
            instr_mem[wr_ptr] <= enq_instr;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed test-plan sequences plus random traffic against a queue-based reference model.
module tb_fetch_queue;
    localparam int AW = 12;
    localparam int IW = 32;
    localparam int D  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset, flush, enq_valid, enq_ready, deq_valid, deq_ready;
    logic [AW-1:0] enq_pc, deq_pc;
    logic [IW-1:0] enq_instr, deq_instr;
    logic [CW-1:0] count;

    int tests = 0;
    int fails = 0;
    bit known = 0;
    logic [AW+IW-1:0] q[$];

    fetch_queue #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc), .enq_instr(enq_instr),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc), .deq_instr(deq_instr),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Applies one cycle of inputs, checks outputs mid-cycle against the model, then advances both.
    task automatic step(input logic r, input logic f, input logic ev, input logic [AW-1:0] pc,
                        input logic [IW-1:0] ins, input logic dr);
        bit byp, full, exp_v, exp_r;
        logic [AW+IW-1:0] head;
        reset = r; flush = f; enq_valid = ev; enq_pc = pc; enq_instr = ins; deq_ready = dr;
        #4;
        byp = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = !f && ev && q.size() == 0;
`endif
        full  = q.size() == D;
        exp_r = r || !full;
        exp_v = !r && (q.size() != 0 || byp);
        head  = r ? '0 : q.size() != 0 ? q[0] : byp ? {pc, ins} : '0;
        check("enq_ready", 64'(enq_ready), 64'(exp_r));
        check("deq_valid", 64'(deq_valid), 64'(exp_v));
        check("deq_pc", 64'(deq_pc), 64'(head[AW+IW-1:IW]));
        check("deq_instr", 64'(deq_instr), 64'(head[IW-1:0]));
        if (known) check("count", 64'(count), 64'(q.size()));
        if (r || f) q.delete();
        else if (!(byp && dr)) begin
            if (dr && q.size() != 0) void'(q.pop_front());
            if (ev && !full) q.push_back({pc, ins});
        end
        if (r) known = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; flush = 0; enq_valid = 0; enq_pc = '0; enq_instr = '0; deq_ready = 0;
        @(posedge clk);
        #1;
        step(1, 0, 0, '0, '0, 0);
        step(1, 0, 0, '0, '0, 0);
        // Fill
        for (int i = 0; i < 4; i++) step(0, 0, 1, AW'(i * 4), IW'(32'h11111111 * (i + 1)), 0);
        check("fill_count", 64'(count), 64'd4);
        check("fill_enq_ready", 64'(enq_ready), 64'd0);
        check("fill_deq_pc", 64'(deq_pc), 64'h000);
        check("fill_deq_instr", 64'(deq_instr), 64'h11111111);
        // Drain
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", 64'(deq_pc), 64'(i * 4));
            step(0, 0, 0, '0, '0, 1);
        end
        check("drain_valid", 64'(deq_valid), 64'd0);
        check("drain_pc_zero", 64'(deq_pc), 64'd0);
        check("drain_count", 64'(count), 64'd0);
        // Simultaneous enqueue/dequeue across pointer wrap
        step(0, 0, 1, 12'h020, 32'hA0, 0);
        step(0, 0, 1, 12'h024, 32'hA1, 0);
        for (int i = 0; i < 6; i++) begin
            check("simul_head", 64'(deq_pc), 64'(12'h020 + i * 4));
            step(0, 0, 1, AW'(12'h028 + i * 4), IW'(32'hB0 + i), 1);
        end
        check("simul_count", 64'(count), 64'd2);
        // Full with dequeue: enqueue rejected, accepted next cycle
        step(0, 0, 1, 12'h050, 32'hC0, 0);
        step(0, 0, 1, 12'h054, 32'hC1, 0);
        check("full_count", 64'(count), 64'd4);
        step(0, 0, 1, 12'h010, 32'hD0, 1);
        check("full_deq_count", 64'(count), 64'd3);
        step(0, 0, 1, 12'h010, 32'hD0, 0);
        check("full_retry_count", 64'(count), 64'd4);
        // Flush mid-stream
        step(0, 0, 0, '0, '0, 1);
        check("pre_flush_count", 64'(count), 64'd3);
        step(0, 1, 1, 12'h100, 32'hE0, 1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(deq_valid), 64'd0);
        step(0, 0, 1, 12'h200, 32'hE1, 0);
        check("post_flush_pc", 64'(deq_pc), 64'h200);
        // Bypass / minimum latency
        step(0, 0, 0, '0, '0, 1);
        step(0, 0, 1, 12'h040, 32'hF0, 1);
`ifdef FETCH_QUEUE_BYPASS_EN
        check("bypass_count", 64'(count), 64'd0);
`else
        check("latency_pc", 64'(deq_pc), 64'h040);
        check("latency_count", 64'(count), 64'd1);
`endif
        // Random traffic with alternating drain pressure and X data on idle enqueue
        for (int i = 0; i < 3000; i++) begin
            int thr;
            logic r, f, ev, dr;
            thr = ((i / 256) % 2 == 0) ? 25 : 80;
            r  = $urandom_range(0, 199) == 0;
            f  = $urandom_range(0, 99) < 2;
            ev = $urandom_range(0, 99) < 70;
            dr = $urandom_range(0, 99) < thr;
            if (ev) step(r, f, 1'b1, AW'($urandom), IW'($urandom), dr);
            else    step(r, f, 1'b0, 'x, 'x, dr);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
